// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter state type for the bus arbiter slice.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_OPEN,
        ST_BURST_FIXED,
        ST_BURST_INCR,
        ST_LOCKED
    } state_e;

    localparam int CNT_W = 4;

    // Beats in a burst; 0 marks the unbounded INCR burst.
    function automatic logic [4:0] burst_beats(input hburst_e b);
        case (b)
            SINGLE:         burst_beats = 5'd1;
            WRAP4, INCR4:   burst_beats = 5'd4;
            WRAP8, INCR8:   burst_beats = 5'd8;
            WRAP16, INCR16: burst_beats = 5'd16;
            default:        burst_beats = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester above last_idx, wrapping,
// with last_idx itself considered last.
module rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MW-1:0]          last_idx,
    output logic [NUM_MASTERS-1:0] grant_onehot,
    output logic [MW-1:0]          grant_idx,
    output logic                   any
);

    logic [MW:0]   sum;
    logic [MW-1:0] idx;

    always_comb begin
        grant_idx = last_idx;
        sum       = '0;
        idx       = '0;
        // Walk from the farthest candidate down so the nearest requester wins.
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            sum = {1'b0, last_idx} + (MW+1)'(k);
            if (sum >= (MW+1)'(NUM_MASTERS))
                sum = sum - (MW+1)'(NUM_MASTERS);
            idx = sum[MW-1:0];
            if (req[idx])
                grant_idx = idx;
        end
        any          = |req;
        grant_onehot = '0;
        if (any)
            grant_onehot[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter that re-arbitrates only at legal handover points
// and holds the grant across fixed bursts, INCR bursts and locked sequences.
//
// state          | meaning
// ST_OPEN        | handover allowed on any accepted non-BUSY cycle
// ST_BURST_FIXED | fixed-length burst in flight, beat_cnt = SEQ beats left
// ST_BURST_INCR  | INCR burst, held while the owner keeps requesting
// ST_LOCKED      | locked owner, held until its hlock drops
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    state_e             state;
    state_e             nxt_state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   nxt_cnt;
    logic               arb_en;
    htrans_e            trans;
    hburst_e            burst;
    logic               accept;

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [MW-1:0]          pick_idx;
    logic                   pick_any;

    assign trans  = htrans_e'(htrans);
    assign burst  = hburst_e'(hburst);
    assign accept = hready && (trans != BUSY);

    rr_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .MW         (MW)
    ) u_rr_pick (
        .req         (hbusreq),
        .last_idx    (hmaster),
        .grant_onehot(pick_onehot),
        .grant_idx   (pick_idx),
        .any         (pick_any)
    );

    always_comb begin
        arb_en    = 1'b0;
        nxt_state = state;
        nxt_cnt   = beat_cnt;
        if (accept) begin
            case (state)
                ST_OPEN, ST_BURST_FIXED: begin
                    if (trans == NONSEQ && burst == INCR) begin
                        nxt_state = ST_BURST_INCR;
                        nxt_cnt   = '0;
                    end else if (trans == NONSEQ && burst != SINGLE) begin
                        nxt_state = ST_BURST_FIXED;
                        nxt_cnt   = CNT_W'(burst_beats(burst) - 5'd1);
                    end else if (state == ST_BURST_FIXED && trans == SEQ &&
                                 beat_cnt != CNT_W'(1)) begin
                        nxt_cnt = beat_cnt - CNT_W'(1);
                    end else begin
                        // SINGLE, IDLE, or the last SEQ of a fixed burst
                        arb_en    = 1'b1;
                        nxt_state = ST_OPEN;
                        nxt_cnt   = '0;
                    end
                end
                ST_BURST_INCR: begin
                    if (!hbusreq[hmaster]) begin
                        arb_en    = 1'b1;
                        nxt_state = ST_OPEN;
                    end
                end
                ST_LOCKED: begin
                    if (!hlock[hmaster]) begin
                        arb_en    = 1'b1;
                        nxt_state = ST_OPEN;
                    end
                end
                default: begin
                    nxt_state = ST_OPEN;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_OPEN;
            beat_cnt  <= '0;
            hgrant    <= NUM_MASTERS'(1);
            hmaster   <= '0;
            hmastlock <= 1'b0;
        end else begin
            state    <= nxt_state;
            beat_cnt <= nxt_cnt;
            if (arb_en) begin
                hmastlock <= 1'b0;
                if (pick_any) begin
                    hgrant    <= pick_onehot;
                    hmaster   <= pick_idx;
                    hmastlock <= hlock[pick_idx];
                    if (hlock[pick_idx])
                        state <= ST_LOCKED;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural ownership model.
module tb_ahb_bus_arbiter;
    import ahb_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic [N-1:0] hbusreq;
    logic [N-1:0] hlock;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic         hready;
    logic [N-1:0] hgrant;
    logic [1:0]   hmaster;
    logic         hmastlock;

    ahb_bus_arbiter #(.NUM_MASTERS(N)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .hbusreq  (hbusreq),
        .hlock    (hlock),
        .htrans   (htrans),
        .hburst   (hburst),
        .hready   (hready),
        .hgrant   (hgrant),
        .hmaster  (hmaster),
        .hmastlock(hmastlock)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] g;
        logic [1:0]   m;
        logic         l;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Model: who owns the bus, how many SEQ beats of a fixed burst remain,
    // whether an INCR burst is open, whether the owner holds a lock.
    int m_owner  = 0;
    int m_left   = 0;
    bit m_incr   = 0;
    bit m_locked = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int fixed_len(input logic [2:0] bu);
        // WRAP4/INCR4 -> 4, WRAP8/INCR8 -> 8, WRAP16/INCR16 -> 16
        return 4 << ((int'(bu) - 2) / 2);
    endfunction

    task automatic model_step(input logic rn, input logic [N-1:0] req, input logic [N-1:0] lock,
                              input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        bit handover;
        int cand;
        if (!rn) begin
            m_owner = 0; m_left = 0; m_incr = 0; m_locked = 0;
            return;
        end
        if (!rdy || tr == BUSY)
            return;
        handover = 0;
        if (m_locked)
            handover = !lock[m_owner];
        else if (m_incr)
            handover = !req[m_owner];
        else if (tr == NONSEQ && bu == INCR) begin
            m_incr = 1; m_left = 0;
        end else if (tr == NONSEQ && bu != SINGLE)
            m_left = fixed_len(bu) - 1;
        else if (tr == SEQ && m_left > 1)
            m_left = m_left - 1;
        else
            handover = 1;
        if (handover) begin
            m_left = 0; m_incr = 0; m_locked = 0;
            for (int k = 1; k <= N; k++) begin
                cand = (m_owner + k) % N;
                if (req[cand]) begin
                    m_owner  = cand;
                    m_locked = lock[cand];
                    break;
                end
            end
        end
    endtask

    task automatic drive(input logic rn, input logic [N-1:0] req, input logic [N-1:0] lock,
                         input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        exp_t e;
        resetn = rn; hbusreq = req; hlock = lock; htrans = tr; hburst = bu; hready = rdy;
        model_step(rn, req, lock, tr, bu, rdy);
        e.g = 4'b0001 << m_owner;
        e.m = 2'(m_owner);
        e.l = m_locked;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one expected word per clock edge, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scoreboard {hgrant,hmaster,hmastlock}", {hgrant, hmaster, hmastlock}, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rr_exp[5] = '{1, 2, 3, 0, 1};
        logic [N-1:0] rq, lk;
        resetn = 1'b0; hbusreq = '1; hlock = '0; htrans = IDLE; hburst = SINGLE; hready = 1'b1;
        model_step(1'b0, '1, '0, IDLE, SINGLE, 1'b1);
        @(negedge clk);

        // Reset held with every master requesting
        repeat (3) drive(1'b0, 4'b1111, 4'b0000, IDLE, SINGLE, 1'b1);
        chk("reset hgrant", hgrant, 4'b0001);
        chk("reset hmaster", hmaster, 0);
        chk("reset hmastlock", hmastlock, 0);

        // Round robin over SINGLE transfers
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
            chk("round robin hmaster", hmaster, rr_exp[i]);
        end

        // INCR8 from master 2 with master 0 waiting and a stall at beat 4
        drive(1'b1, 4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
        chk("grant to 2", hmaster, 2);
        drive(1'b1, 4'b0101, 4'b0000, NONSEQ, INCR8, 1'b1);
        repeat (3) drive(1'b1, 4'b0101, 4'b0000, SEQ, INCR8, 1'b1);
        repeat (2) drive(1'b1, 4'b0101, 4'b0000, SEQ, INCR8, 1'b0);
        chk("incr8 stall hold", hmaster, 2);
        repeat (3) drive(1'b1, 4'b0101, 4'b0000, SEQ, INCR8, 1'b1);
        chk("incr8 before last beat", hmaster, 2);
        drive(1'b1, 4'b0101, 4'b0000, SEQ, INCR8, 1'b1);
        chk("incr8 handover", hmaster, 0);

        // INCR4 with a BUSY after beat 2
        drive(1'b1, 4'b0011, 4'b0000, NONSEQ, INCR4, 1'b1);
        drive(1'b1, 4'b0011, 4'b0000, SEQ, INCR4, 1'b1);
        drive(1'b1, 4'b0011, 4'b0000, BUSY, INCR4, 1'b1);
        drive(1'b1, 4'b0011, 4'b0000, SEQ, INCR4, 1'b1);
        chk("busy burst hold", hmaster, 0);
        drive(1'b1, 4'b0011, 4'b0000, SEQ, INCR4, 1'b1);
        chk("busy burst handover", hmaster, 1);

        // Locked master 1 while master 3 requests
        drive(1'b1, 4'b0010, 4'b0010, IDLE, SINGLE, 1'b1);
        repeat (3) drive(1'b1, 4'b1010, 4'b0010, NONSEQ, SINGLE, 1'b1);
        chk("lock hmaster", hmaster, 1);
        chk("lock hmastlock", hmastlock, 1);
        drive(1'b1, 4'b1010, 4'b0000, NONSEQ, SINGLE, 1'b0);
        chk("unlock stalled", hmaster, 1);
        drive(1'b1, 4'b1010, 4'b0000, NONSEQ, SINGLE, 1'b1);
        chk("unlock handover", hmaster, 3);
        chk("unlock hmastlock", hmastlock, 0);

        // Reset during beat 5 of an INCR16
        drive(1'b1, 4'b1001, 4'b0000, NONSEQ, INCR16, 1'b1);
        repeat (3) drive(1'b1, 4'b1001, 4'b0000, SEQ, INCR16, 1'b1);
        resetn = 1'b0;
        #1;
        chk("async reset hgrant", hgrant, 4'b0001);
        chk("async reset hmaster", hmaster, 0);
        drive(1'b0, 4'b1001, 4'b0000, SEQ, INCR16, 1'b1);
        drive(1'b0, 4'b1001, 4'b0000, SEQ, INCR16, 1'b1);
        drive(1'b1, 4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
        chk("post reset arbitration", hmaster, 2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rq = 4'($urandom_range(0, 15));
            lk = ($urandom_range(0, 5) == 0) ? (4'($urandom_range(0, 15)) & rq) : 4'b0000;
            drive(1'b1, rq, lk, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 4) != 0));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Round-robin AHB bus arbiter granting one of `NUM_MASTERS` requesters access to a shared AHB address/data bus. It watches the muxed bus (`htrans`, `hburst`, `hready`) and re-arbitrates only at legal AHB handover points. A grant is held for the whole of a fixed-length burst, for an INCR burst while its owner keeps requesting, and for a locked sequence. It sits beside the address/data mux, which selects the master using `hmaster`. It is the block the bound AHB assertion interfaces observe.

## Interface
- `NUM_MASTERS`, default 4: number of requesters, range 2..16.
- `MW`, default `$clog2(NUM_MASTERS)`: width of `hmaster`; derived, do not override.
- `clk`  in  1: bus clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `hbusreq`  in  NUM_MASTERS: per-master bus request.
- `hlock`  in  NUM_MASTERS: per-master lock request; only meaningful together with `hbusreq`.
- `htrans`  in  2: transfer type on the muxed bus.
- `hburst`  in  3: burst type on the muxed bus.
- `hready`  in  1: bus ready; a transfer phase completes when high.
- `hgrant`  out  NUM_MASTERS: one-hot grant, registered.
- `hmaster`  out  MW: index of the owning master, registered; always the index of the `hgrant` bit.
- `hmastlock`  out  1: current owner holds a locked grant, registered.

## Operation
- **Reset values:** `hgrant` = 1 (master 0 parked); `hmaster` = 0; `hmastlock` = 0; beat counter = 0; state = OPEN.
- **State machine:** OPEN, BURST_FIXED, BURST_INCR, LOCKED.
  - OPEN: arbitration is allowed on any cycle with `hready` = 1.
  - OPEN → BURST_FIXED: NONSEQ accepted (`hready` = 1) with `hburst` ∈ {WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16}. Beat counter loads len−1 (3, 7 or 15).
  - OPEN → BURST_INCR: NONSEQ accepted with `hburst` = INCR.
  - SINGLE NONSEQ: stays OPEN.
  - BURST_FIXED: each accepted SEQ decrements the counter. The accepted SEQ with counter = 1 brings the counter to 0 and returns to OPEN. Arbitration is allowed in that same cycle.
  - BURST_INCR: stays while `hbusreq[hmaster]` = 1. Returns to OPEN, with arbitration allowed in the same cycle, when `hbusreq[hmaster]` = 0 and `hready` = 1.
  - LOCKED: entered from any state when arbitration selects a master with `hlock` = 1. No re-arbitration while `hlock[hmaster]` = 1. Exits to OPEN on the first `hready` = 1 cycle with `hlock[hmaster]` = 0.
- **BUSY** (`htrans` = 01): no counter change, no arbitration, no state change.
- **Early termination:** IDLE accepted in BURST_FIXED clears the counter and goes to OPEN. A NONSEQ accepted in BURST_FIXED reloads the counter per the new `hburst`.
- **Selection (round robin):** the first master with `hbusreq` = 1 searching upward from `hmaster`+1, wrapping to 0. The current owner has the lowest priority and is chosen only if it is the sole requester. With no requests, the grant stays parked on the current owner.
- **Lock flag:** `hmastlock` is set to `hlock` of the newly selected master. It is cleared on exit from LOCKED.
- **Stall:** `hready` = 0 freezes the state, the counter and the grant.

## Timing
- **Grant latency:** arbitration decision in cycle N (with `hready` = 1) → `hgrant`/`hmaster` update at edge N+1. The new owner drives NONSEQ from cycle N+1.
- **Fixed-burst hold:** the grant never changes between an accepted fixed-length NONSEQ and acceptance of its last SEQ beat.
- **Simultaneous events:** last beat accepted while another master requests → that master is granted at N+1. Owner drops `hbusreq` on an `hready` = 0 cycle → arbitration waits for `hready` = 1.
- **Reset mid-burst:** all outputs return to reset values immediately (asynchronous).

## Structure
- **Package `ahb_pkg`:** `htrans_e` (IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3), `hburst_e` (SINGLE … INCR16 per AHB encoding), function `burst_beats(hburst_e)`, and the arbiter `state_e`.
- **Sub-module `rr_pick`:** combinational round-robin picker (`req`, `last_idx` → `grant_onehot`, `grant_idx`, `any`).

## Test plan
- **Reset:** hold `resetn` = 0 for 3 cycles with all `hbusreq` set → `hgrant` = 0001, `hmaster` = 0, `hmastlock` = 0.
- **Round robin:** `hbusreq` = 1111, SINGLE NONSEQ each cycle with `hready` = 1 → `hmaster` sequence 1, 2, 3, 0, 1.
- **INCR8 hold:** master 2 issues NONSEQ INCR8 plus 7 SEQ, with master 0 requesting and a 2-cycle `hready` = 0 stall at beat 4 → grant stays on 2 for all beats. `hmaster` = 0 one cycle after the 7th SEQ is accepted.
- **BUSY inside burst:** INCR4 with BUSY inserted after beat 2 → counter unchanged across BUSY, handover after beat 4.
- **Lock:** master 1 has `hlock` = 1 and `hbusreq` = 1 across 3 SINGLE transfers while master 3 requests → `hmastlock` = 1 and no handover. Drop `hlock` → grant moves to 3 at the next `hready` = 1 + 1 cycle.
- **Reset mid-burst:** assert `resetn` = 0 during beat 5 of an INCR16 → `hgrant` = 0001 immediately. After release, arbitration restarts in OPEN.
